// File: rtl/matmul_mem.sv
// Single-port scratchpad for matmul operands/results with a registered read, a readable window
// and a one-word-per-cycle clear sequencer. Define MATMUL_MEM_BYPASS_EN for write-through reads.
module matmul_mem #(
   parameter int unsigned DATA_W     = 18,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned READ_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic [ADDR_W-1:0] addr,
   input  logic              memWrite,
   input  logic              memRead,
   input  logic              clear,
   output logic [DATA_W-1:0] out,
   output logic              out_valid,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] RD_LIMIT  = ADDR_W'(READ_LIMIT);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0]   out_q, out_d;
   logic                out_valid_q, out_valid_d;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_wa;
   logic [DATA_W-1:0]   mem_wd;
   logic [DATA_W-1:0]   rd_word;
   logic                in_depth;
   logic                in_window;

   assign in_depth  = ({1'b0, addr} < DEPTH_EXT);
   assign in_window = (addr <= RD_LIMIT);

`ifdef MATMUL_MEM_BYPASS_EN
   // Write-through: a same-edge write is visible to the read it accompanies.
   assign rd_word = memWrite ? data_in : mem[addr];
`else
   assign rd_word = mem[addr];
`endif

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      out_d       = '0;
      out_valid_d = 1'b0;
      mem_we      = 1'b0;
      mem_wa      = addr;
      mem_wd      = data_in;
      unique case (state_q)
         StClear: begin
            mem_we    = 1'b1;
            mem_wa    = clr_cnt_q;
            mem_wd    = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_IDX) begin
               state_d = StIdle;
            end
         end
         StIdle: begin
            if (clear) begin
               state_d   = StClear;
               clr_cnt_d = '0;
            end else begin
               mem_we = memWrite && in_depth;
               if (memRead) begin
                  out_valid_d = 1'b1;
                  out_d       = in_window ? rd_word : '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StClear;
         clr_cnt_q   <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Array has no reset; the clear sequencer zeroes it after every reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q == StClear);

endmodule

// File: tb/tb_matmul_mem.sv
// Self-checking bench for matmul_mem: default-parameter instance plus a small parameter-sweep
// instance, checked against an array-based reference model.
module tb_matmul_mem;

   localparam int DW   = 18;
   localparam int AW   = 5;
   localparam int DP   = 32;
   localparam int RL   = 8;
   localparam int DW_B = 8;
   localparam int AW_B = 4;
   localparam int DP_B = 12;
   localparam int RL_B = 11;
`ifdef MATMUL_MEM_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] data_in = '0;
   logic [AW-1:0] addr = '0;
   logic          memWrite = 1'b0;
   logic          memRead = 1'b0;
   logic          clear = 1'b0;
   logic [DW-1:0] out;
   logic          out_valid;
   logic          busy;

   logic            rst_b = 1'b1;
   logic [DW_B-1:0] data_in_b = '0;
   logic [AW_B-1:0] addr_b = '0;
   logic            memWrite_b = 1'b0;
   logic            memRead_b = 1'b0;
   logic            clear_b = 1'b0;
   logic [DW_B-1:0] out_b;
   logic            out_valid_b;
   logic            busy_b;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0]   ref_a [DP];
   logic [DW_B-1:0] ref_b [16];
   int              busy_left_a = 0;
   logic [DW-1:0]   exp_out;
   logic            exp_valid;
   logic            exp_busy;

   matmul_mem dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .addr      (addr),
      .memWrite  (memWrite),
      .memRead   (memRead),
      .clear     (clear),
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy)
   );

   matmul_mem #(
      .DATA_W     (DW_B),
      .ADDR_W     (AW_B),
      .DEPTH      (DP_B),
      .READ_LIMIT (RL_B)
   ) dut_b (
      .clk       (clk),
      .rst       (rst_b),
      .data_in   (data_in_b),
      .addr      (addr_b),
      .memWrite  (memWrite_b),
      .memRead   (memRead_b),
      .clear     (clear_b),
      .out       (out_b),
      .out_valid (out_valid_b),
      .busy      (busy_b)
   );

   always #5 clk = ~clk;

   // One clock of stimulus on the default instance; the model predicts the post-edge outputs.
   task automatic step_a(input logic we, input logic re, input logic clr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
      memWrite = we;
      memRead  = re;
      clear    = clr;
      addr     = a;
      data_in  = d;
      if (busy_left_a > 0) begin
         busy_left_a--;
         exp_out   = '0;
         exp_valid = 1'b0;
         exp_busy  = (busy_left_a > 0);
      end else if (clr) begin
         busy_left_a = DP;
         foreach (ref_a[i]) ref_a[i] = '0;
         exp_out   = '0;
         exp_valid = 1'b0;
         exp_busy  = 1'b1;
      end else begin
         exp_valid = re;
         exp_out   = '0;
         if (re && int'(a) <= RL) exp_out = (we && BYP) ? d : ref_a[a];
         if (we) ref_a[a] = d;
         exp_busy = 1'b0;
      end
      @(posedge clk);
      #1;
      memWrite = 1'b0;
      memRead  = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (out !== '0 || out_valid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL reset_hold: out=%h valid=%b busy=%b, expected out=0 valid=0 busy=1",
                  out, out_valid, busy);
      end
      rst = 1'b0;
      busy_left_a = DP;
      foreach (ref_a[i]) ref_a[i] = '0;
      for (int i = 0; i < DP; i++) begin
         step_a(1'b0, 1'b0, 1'b0, '0, '0);
         total++;
         if (busy !== exp_busy || out_valid !== exp_valid) begin
            bad++;
            $display("FAIL reset_clear edge %0d: busy=%b valid=%b, expected busy=%b valid=%b",
                     i + 1, busy, out_valid, exp_busy, exp_valid);
         end
      end
      for (int i = 0; i <= RL; i++) begin
         step_a(1'b0, 1'b1, 1'b0, AW'(i), '0);
         total++;
         if (out !== exp_out || out_valid !== exp_valid || busy !== exp_busy) begin
            bad++;
            $display("FAIL reset_read a=%0d: out=%h valid=%b busy=%b, expected out=%h valid=%b busy=%b",
                     i, out, out_valid, busy, exp_out, exp_valid, exp_busy);
         end
      end
   endtask

   task automatic test_window;
      logic [AW-1:0] seq [3];
      seq[0] = 5'd8;
      seq[1] = 5'd0;
      seq[2] = 5'd9;
      step_a(1'b1, 1'b0, 1'b0, 5'd8, 18'h3FFFF);
      step_a(1'b1, 1'b0, 1'b0, 5'd0, 18'h00001);
      for (int i = 0; i < 3; i++) begin
         step_a(1'b0, 1'b1, 1'b0, seq[i], '0);
         total++;
         if (out !== exp_out || out_valid !== 1'b1 || exp_valid !== 1'b1) begin
            bad++;
            $display("FAIL window_read a=%0d: out=%h valid=%b, expected out=%h valid=1",
                     seq[i], out, out_valid, exp_out);
         end
      end
   endtask

   task automatic test_busy_requests;
      step_a(1'b1, 1'b0, 1'b0, 5'd3, 18'h12345);
      step_a(1'b0, 1'b1, 1'b0, 5'd3, '0);
      total++;
      if (out !== 18'h12345 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL busy_preload: out=%h valid=%b, expected out=12345 valid=1", out, out_valid);
      end
      step_a(1'b0, 1'b0, 1'b1, '0, '0);
      for (int i = 0; i < DP; i++) begin
         step_a(1'b1, 1'b1, 1'b0, 5'd3, 18'h0AAAA);
         total++;
         if (out !== exp_out || out_valid !== exp_valid || busy !== exp_busy) begin
            bad++;
            $display("FAIL busy_req cycle %0d: out=%h valid=%b busy=%b, expected out=%h valid=%b busy=%b",
                     i, out, out_valid, busy, exp_out, exp_valid, exp_busy);
         end
      end
      step_a(1'b0, 1'b1, 1'b0, 5'd3, '0);
      total++;
      if (out !== 18'h0 || out_valid !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_after: out=%h valid=%b busy=%b, expected out=0 valid=1 busy=0",
                  out, out_valid, busy);
      end
   endtask

   task automatic test_same_addr;
      logic [DW-1:0] want;
      want = BYP ? 18'h00222 : 18'h00111;
      step_a(1'b1, 1'b0, 1'b0, 5'd5, 18'h00111);
      step_a(1'b1, 1'b1, 1'b0, 5'd5, 18'h00222);
      total++;
      if (out !== want || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL same_addr_rw: out=%h valid=%b, expected out=%h valid=1", out, out_valid, want);
      end
      step_a(1'b0, 1'b1, 1'b0, 5'd5, '0);
      total++;
      if (out !== 18'h00222 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL same_addr_after: out=%h valid=%b, expected out=00222 valid=1", out, out_valid);
      end
   endtask

   task automatic test_reset_mid_clear;
      step_a(1'b0, 1'b0, 1'b1, '0, '0);
      for (int i = 0; i < 9; i++) step_a(1'b0, 1'b1, 1'b0, AW'(i), '0);
      @(posedge clk);
      rst = 1'b1;
      #1;
      total++;
      if (out !== '0 || out_valid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL midclear_rst: out=%h valid=%b busy=%b, expected out=0 valid=0 busy=1",
                  out, out_valid, busy);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      busy_left_a = DP;
      foreach (ref_a[i]) ref_a[i] = '0;
      for (int i = 0; i < DP; i++) begin
         step_a(1'b0, 1'b1, 1'b0, 5'd1, '0);
         total++;
         if (busy !== exp_busy || out_valid !== exp_valid || out !== exp_out) begin
            bad++;
            $display("FAIL midclear_restart edge %0d: busy=%b valid=%b, expected busy=%b valid=%b",
                     i + 1, busy, out_valid, exp_busy, exp_valid);
         end
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         step_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 39) == 0), AW'($urandom_range(0, DP - 1)), DW'($urandom));
         total++;
         if (out !== exp_out || out_valid !== exp_valid || busy !== exp_busy) begin
            bad++;
            $display("FAIL random cycle %0d: out=%h valid=%b busy=%b, expected out=%h valid=%b busy=%b",
                     i, out, out_valid, busy, exp_out, exp_valid, exp_busy);
         end
      end
   endtask

   task automatic test_sweep;
      int            n;
      logic [DW_B-1:0] d;
      logic [DW_B-1:0] want;
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (busy_b === 1'b1 && n < 100);
      total++;
      if (n !== DP_B) begin
         bad++;
         $display("FAIL sweep_reset_len: busy edges=%0d, expected %0d", n, DP_B);
      end
      for (int a = 0; a < 16; a++) begin
         d = DW_B'($urandom);
         memWrite_b = 1'b1;
         addr_b     = AW_B'(a);
         data_in_b  = d;
         @(posedge clk);
         #1;
         if (a < DP_B) ref_b[a] = d;
      end
      memWrite_b = 1'b0;
      for (int a = 0; a < 16; a++) begin
         memRead_b = 1'b1;
         addr_b    = AW_B'(a);
         @(posedge clk);
         #1;
         want = (a <= RL_B) ? ref_b[a] : '0;
         total++;
         if (out_b !== want || out_valid_b !== 1'b1) begin
            bad++;
            $display("FAIL sweep_read a=%0d: out=%h valid=%b, expected out=%h valid=1",
                     a, out_b, out_valid_b, want);
         end
      end
      memRead_b = 1'b0;
      clear_b   = 1'b1;
      @(posedge clk);
      #1;
      clear_b = 1'b0;
      total++;
      if (busy_b !== 1'b1) begin
         bad++;
         $display("FAIL sweep_clear_accept: busy=%b, expected 1", busy_b);
      end
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (busy_b === 1'b1 && n < 100);
      total++;
      if (n !== DP_B) begin
         bad++;
         $display("FAIL sweep_clear_len: edges=%0d, expected %0d", n, DP_B);
      end
      for (int a = 0; a < DP_B; a++) begin
         memRead_b = 1'b1;
         addr_b    = AW_B'(a);
         @(posedge clk);
         #1;
         total++;
         if (out_b !== '0 || out_valid_b !== 1'b1) begin
            bad++;
            $display("FAIL sweep_cleared a=%0d: out=%h valid=%b, expected out=0 valid=1",
                     a, out_b, out_valid_b);
         end
      end
      memRead_b = 1'b0;
   endtask

   initial begin
      test_reset();
      test_window();
      test_busy_requests();
      test_same_addr();
      test_reset_mid_clear();
      test_random();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
